// File: rtl/raster_pkg.sv
// Shared types for the primitive assembler: topology and state encodings,
// the packed vertex layout used by vertex_fifo, and screen x/y offsets.
// Optional feature macro: PRIM_ASM_CULL_EN (adds the CULL state).
package raster_pkg;

   typedef enum logic [1:0] {
      TOPO_LIST  = 2'd0,
      TOPO_STRIP = 2'd1,
      TOPO_FAN   = 2'd2
   } topo_e;

`ifdef PRIM_ASM_CULL_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EMIT  = 2'd2,
      ST_CULL  = 2'd3
   } asm_state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EMIT  = 2'd2
   } asm_state_e;
`endif

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [7:0]  z;
      logic [31:0] u;
      logic [31:0] v;
   } vertex_t;

   localparam int X_LSB_C = 88;
   localparam int Y_LSB_C = 72;

   // Mode 3 is reserved and behaves as a plain list.
   function automatic topo_e decode_mode(input logic [1:0] m);
      topo_e t;
      case (m)
         2'd1:    t = TOPO_STRIP;
         2'd2:    t = TOPO_FAN;
         default: t = TOPO_LIST;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/tri_area.sv
// Combinational screen-space signed area (twice the triangle area).
// Positive result means counter-clockwise winding in emit order.
module tri_area #(
   parameter int COORD_W = 16
) (
   input  logic signed [COORD_W-1:0]   x0,
   input  logic signed [COORD_W-1:0]   y0,
   input  logic signed [COORD_W-1:0]   x1,
   input  logic signed [COORD_W-1:0]   y1,
   input  logic signed [COORD_W-1:0]   x2,
   input  logic signed [COORD_W-1:0]   y2,
   output logic signed [2*COORD_W+2:0] area
);

   localparam int DW = COORD_W + 1;
   localparam int PW = 2*COORD_W + 2;

   logic signed [DW-1:0] dx1;
   logic signed [DW-1:0] dy1;
   logic signed [DW-1:0] dx2;
   logic signed [DW-1:0] dy2;
   logic signed [PW-1:0] p0;
   logic signed [PW-1:0] p1;

   // Edge differences, products and their difference, each one bit wider than needed to avoid overflow.
   always_comb begin
      dx1  = $signed({x1[COORD_W-1], x1}) - $signed({x0[COORD_W-1], x0});
      dy1  = $signed({y1[COORD_W-1], y1}) - $signed({y0[COORD_W-1], y0});
      dx2  = $signed({x2[COORD_W-1], x2}) - $signed({x0[COORD_W-1], x0});
      dy2  = $signed({y2[COORD_W-1], y2}) - $signed({y0[COORD_W-1], y0});
      p0   = $signed({{(PW-DW){dx1[DW-1]}}, dx1}) * $signed({{(PW-DW){dy2[DW-1]}}, dy2});
      p1   = $signed({{(PW-DW){dx2[DW-1]}}, dx2}) * $signed({{(PW-DW){dy1[DW-1]}}, dy1});
      area = $signed({p0[PW-1], p0}) - $signed({p1[PW-1], p1});
   end

endmodule

// File: rtl/primitive_assembler.sv
// Pops vertices from vertex_fifo and groups them into list/strip/fan
// triangles, emitted as {v0,v1,v2} on a valid/ready port.
// Optional macro PRIM_ASM_CULL_EN adds back-face/degenerate culling.
module primitive_assembler
   import raster_pkg::*;
#(
   parameter int VERTEX_W = 104,
   parameter int X_LSB    = 88,
   parameter int Y_LSB    = 72,
   parameter int COORD_W  = 16,
   parameter int CNT_W    = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [1:0]            i_mode,
   input  logic                  i_restart,
   output logic                  o_fifo_re,
   input  logic [VERTEX_W-1:0]   i_fifo_data,
   input  logic                  i_fifo_empty,
   output logic                  o_tri_valid,
   input  logic                  i_tri_ready,
   output logic [3*VERTEX_W-1:0] o_tri_data,
   output logic [CNT_W-1:0]      o_prim_count,
   output logic [CNT_W-1:0]      o_cull_count
);

   asm_state_e          state;
   logic [1:0]          vcnt;
   logic                parity;
   topo_e               mode_q;
   logic                restart_pend;
   logic [VERTEX_W-1:0] slot0;
   logic [VERTEX_W-1:0] slot1;
   logic [VERTEX_W-1:0] slot2;

   logic [VERTEX_W-1:0] ord0;
   logic [VERTEX_W-1:0] ord1;
   logic [VERTEX_W-1:0] ord2;

   logic                adv_clear;
   logic [VERTEX_W-1:0] adv_slot0;
   logic [VERTEX_W-1:0] adv_slot1;
   logic [1:0]          adv_vcnt;
   logic                adv_parity;

   // Reads are only issued from IDLE, never from an empty FIFO, and never while in reset.
   assign o_fifo_re = i_rst_n & (state == ST_IDLE) & ~i_fifo_empty;

   // Emit order for a triangle completed by the vertex arriving this cycle; odd strip triangles swap v0/v1.
   always_comb begin
      ord2 = i_fifo_data;
      if (parity && (mode_q == TOPO_STRIP)) begin
         ord0 = slot1;
         ord1 = slot0;
      end else begin
         ord0 = slot0;
         ord1 = slot1;
      end
   end

   // Slot/count/parity after a triangle leaves (emitted or culled); a pending restart wins over topology.
   always_comb begin
      adv_clear  = restart_pend | i_restart;
      adv_slot0  = slot0;
      adv_slot1  = slot1;
      adv_vcnt   = 2'd0;
      adv_parity = 1'b0;
      if (!adv_clear) begin
         case (mode_q)
            TOPO_STRIP: begin
               adv_slot0  = slot1;
               adv_slot1  = slot2;
               adv_vcnt   = 2'd2;
               adv_parity = ~parity;
            end
            TOPO_FAN: begin
               adv_slot1  = slot2;
               adv_vcnt   = 2'd2;
               adv_parity = parity;
            end
            default: begin
               adv_vcnt   = 2'd0;
               adv_parity = 1'b0;
            end
         endcase
      end else begin
         adv_vcnt   = 2'd0;
         adv_parity = 1'b0;
      end
   end

`ifdef PRIM_ASM_CULL_EN
   logic signed [2*COORD_W+2:0] area_c;
   logic signed [2*COORD_W+2:0] area_q;
   logic [CNT_W-1:0]            cull_count;
   logic                        cull_hit;

   tri_area #(
      .COORD_W (COORD_W)
   ) u_tri_area (
      .x0   (ord0[X_LSB +: COORD_W]),
      .y0   (ord0[Y_LSB +: COORD_W]),
      .x1   (ord1[X_LSB +: COORD_W]),
      .y1   (ord1[Y_LSB +: COORD_W]),
      .x2   (ord2[X_LSB +: COORD_W]),
      .y2   (ord2[Y_LSB +: COORD_W]),
      .area (area_c)
   );

   // Zero or negative area is either clockwise or degenerate.
   assign cull_hit     = area_q[2*COORD_W+2] | (area_q == '0);
   assign o_cull_count = cull_count;
`else
   assign o_cull_count = {CNT_W{1'b0}};
`endif

   // Assembler FSM with registered triangle outputs and statistics counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= ST_IDLE;
         vcnt         <= 2'd0;
         parity       <= 1'b0;
         mode_q       <= TOPO_LIST;
         restart_pend <= 1'b0;
         slot0        <= {VERTEX_W{1'b0}};
         slot1        <= {VERTEX_W{1'b0}};
         slot2        <= {VERTEX_W{1'b0}};
         o_tri_valid  <= 1'b0;
         o_tri_data   <= {(3*VERTEX_W){1'b0}};
         o_prim_count <= {CNT_W{1'b0}};
`ifdef PRIM_ASM_CULL_EN
         area_q       <= '0;
         cull_count   <= {CNT_W{1'b0}};
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_restart) begin
                  vcnt   <= 2'd0;
                  parity <= 1'b0;
               end
               if (o_fifo_re) begin
                  state <= ST_FETCH;
               end else begin
                  state <= ST_IDLE;
               end
            end

            ST_FETCH: begin
               if (i_restart) begin
                  // The vertex in flight starts a fresh primitive.
                  slot0  <= i_fifo_data;
                  mode_q <= decode_mode(i_mode);
                  vcnt   <= 2'd1;
                  parity <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  case (vcnt)
                     2'd0: begin
                        slot0  <= i_fifo_data;
                        mode_q <= decode_mode(i_mode);
                     end
                     2'd1:    slot1 <= i_fifo_data;
                     default: slot2 <= i_fifo_data;
                  endcase
                  vcnt <= vcnt + 2'd1;
                  if (vcnt == 2'd2) begin
                     o_tri_data <= {ord0, ord1, ord2};
`ifdef PRIM_ASM_CULL_EN
                     area_q     <= area_c;
                     state      <= ST_CULL;
`else
                     o_tri_valid <= 1'b1;
                     state       <= ST_EMIT;
`endif
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end

`ifdef PRIM_ASM_CULL_EN
            ST_CULL: begin
               if (cull_hit) begin
                  if (cull_count != {CNT_W{1'b1}}) begin
                     cull_count <= cull_count + {{(CNT_W-1){1'b0}}, 1'b1};
                  end
                  slot0        <= adv_slot0;
                  slot1        <= adv_slot1;
                  vcnt         <= adv_vcnt;
                  parity       <= adv_parity;
                  restart_pend <= 1'b0;
                  state        <= ST_IDLE;
               end else begin
                  o_tri_valid <= 1'b1;
                  if (i_restart) begin
                     restart_pend <= 1'b1;
                  end
                  state <= ST_EMIT;
               end
            end
`endif

            ST_EMIT: begin
               if (i_tri_ready) begin
                  o_tri_valid  <= 1'b0;
                  o_prim_count <= o_prim_count + {{(CNT_W-1){1'b0}}, 1'b1};
                  slot0        <= adv_slot0;
                  slot1        <= adv_slot1;
                  vcnt         <= adv_vcnt;
                  parity       <= adv_parity;
                  restart_pend <= 1'b0;
                  state        <= ST_IDLE;
               end else begin
                  if (i_restart) begin
                     restart_pend <= 1'b1;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_primitive_assembler.sv
// Scoreboard bench for primitive_assembler: a FIFO model feeds directed
// vertices, expected triangles are queued at stimulus time and a monitor
// compares each handshake. Cull checks run when PRIM_ASM_CULL_EN is defined.
module tb_primitive_assembler;

   localparam int VW = 104;
   localparam int TW = 3*VW;

   logic          clk;
   logic          rst_n;
   logic [1:0]    mode;
   logic          restart;
   logic          fifo_re;
   logic [VW-1:0] fifo_data;
   logic          fifo_empty;
   logic          tri_valid;
   logic          tri_ready;
   logic [TW-1:0] tri_data;
   logic [31:0]   prim_count;
   logic [31:0]   cull_count;

   int compared;
   int mismatched;
   int empty_reads;

   logic [VW-1:0] mem [0:63];
   int            push_cnt;
   int            pop_cnt;
   logic [TW-1:0] exp_q [$];

   primitive_assembler dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_mode       (mode),
      .i_restart    (restart),
      .o_fifo_re    (fifo_re),
      .i_fifo_data  (fifo_data),
      .i_fifo_empty (fifo_empty),
      .o_tri_valid  (tri_valid),
      .i_tri_ready  (tri_ready),
      .o_tri_data   (tri_data),
      .o_prim_count (prim_count),
      .o_cull_count (cull_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_empty = (push_cnt == pop_cnt);

   // FIFO model with one-cycle registered read.
   always @(posedge clk) begin
      if (fifo_re) begin
         fifo_data <= mem[pop_cnt[5:0]];
         pop_cnt   <= pop_cnt + 1;
      end
   end

   function automatic logic [VW-1:0] mkv(input logic [15:0] x, input logic [15:0] y, input logic [7:0] tag);
      return {x, y, tag, {24'h0, tag}, ~{24'h0, tag}};
   endfunction

   task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted triangle must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && tri_valid && tri_ready) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_tri: got %h expected none", tri_data);
         end else begin
            chk("tri_data", tri_data, exp_q.pop_front());
         end
      end
      if (fifo_re && fifo_empty) empty_reads++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_v(input logic [VW-1:0] v);
      mem[push_cnt[5:0]] = v;
      push_cnt = push_cnt + 1;
   endtask

   task automatic expect_tri(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [VW-1:0] c);
      exp_q.push_back({a, b, c});
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || push_cnt != pop_cnt) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) begin
         compared++;
         mismatched++;
         $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
      end
      repeat (4) step();
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n;
      n = 0;
      while (!tri_valid && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) begin
         compared++;
         mismatched++;
         $display("FAIL %s_timeout: got valid 0 expected 1", name);
      end
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      step();
      restart = 1'b0;
      step();
   endtask

   logic [VW-1:0] va, vb, vc, vd, ve, vf;

   initial begin
      compared    = 0;
      mismatched  = 0;
      empty_reads = 0;
      push_cnt    = 0;
      pop_cnt     = 0;
      fifo_data   = '0;
      rst_n       = 1'b0;
      mode        = 2'd0;
      restart     = 1'b0;
      tri_ready   = 1'b1;
      va = mkv(16'd1,  16'd2,  8'hA1);
      vb = mkv(16'd30, 16'd4,  8'hB2);
      vc = mkv(16'd5,  16'd60, 8'hC3);
      vd = mkv(16'd70, 16'd8,  8'hD4);
      ve = mkv(16'd9,  16'd90, 8'hE5);
      vf = mkv(16'd11, 16'd12, 8'hF6);

      // Reset state, with a vertex already waiting in the FIFO.
      push_v(va);
      repeat (3) step();
      chk("rst_fifo_re", TW'(fifo_re), TW'(1'b0));
      chk("rst_valid", TW'(tri_valid), TW'(1'b0));
      chk("rst_data", tri_data, {TW{1'b0}});
      chk("rst_prim_count", TW'(prim_count), TW'(0));
      chk("rst_cull_count", TW'(cull_count), TW'(0));

      // List: A..F -> {A,B,C},{D,E,F}.
      expect_tri(va, vb, vc);
      expect_tri(vd, ve, vf);
      rst_n = 1'b1;
      push_v(vb); push_v(vc); push_v(vd); push_v(ve); push_v(vf);
      wait_drain("list", 200);
      chk("list_prim_count", TW'(prim_count), TW'(2));

      // Strip: A..E -> {A,B,C},{C,B,D},{C,D,E}.
      mode = 2'd1;
      expect_tri(va, vb, vc);
      expect_tri(vc, vb, vd);
      expect_tri(vc, vd, ve);
      push_v(va); push_v(vb); push_v(vc); push_v(vd); push_v(ve);
      wait_drain("strip", 200);
      chk("strip_prim_count", TW'(prim_count), TW'(5));
      pulse_restart();

      // Fan: A..E -> {A,B,C},{A,C,D},{A,D,E}.
      mode = 2'd2;
      expect_tri(va, vb, vc);
      expect_tri(va, vc, vd);
      expect_tri(va, vd, ve);
      push_v(va); push_v(vb); push_v(vc); push_v(vd); push_v(ve);
      wait_drain("fan", 200);
      chk("fan_prim_count", TW'(prim_count), TW'(8));
      pulse_restart();

      // Backpressure: data stable and no reads while the triangle waits.
      mode      = 2'd0;
      tri_ready = 1'b0;
      expect_tri(va, vb, vc);
      expect_tri(vd, ve, vf);
      push_v(va); push_v(vb); push_v(vc);
      wait_valid("bp", 50);
      push_v(vd);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_data_stable", tri_data, {va, vb, vc});
         chk("bp_fifo_re", TW'(fifo_re), TW'(1'b0));
         chk("bp_valid_held", TW'(tri_valid), TW'(1'b1));
      end
      step();
      tri_ready = 1'b1;
      push_v(ve); push_v(vf);
      wait_drain("bp", 200);
      chk("bp_prim_count", TW'(prim_count), TW'(10));

      // Empty FIFO: idle for a while, no read may appear.
      repeat (20) step();
      chk("empty_reads", TW'(empty_reads), TW'(0));

      // Restart in IDLE discards A,B.
      push_v(va); push_v(vb);
      wait_drain("rs_ab", 100);
      pulse_restart();
      expect_tri(vc, vd, ve);
      push_v(vc); push_v(vd); push_v(ve);
      wait_drain("restart", 200);
      chk("restart_prim_count", TW'(prim_count), TW'(11));

      // Async reset while a triangle is held in EMIT.
      tri_ready = 1'b0;
      push_v(va); push_v(vb); push_v(vc);
      wait_valid("arst", 50);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", TW'(tri_valid), TW'(1'b0));
      chk("arst_data", tri_data, {TW{1'b0}});
      chk("arst_prim_count", TW'(prim_count), TW'(0));
      step();
      rst_n     = 1'b1;
      tri_ready = 1'b1;
      repeat (4) step();

`ifdef PRIM_ASM_CULL_EN
      // CCW kept, reversed and collinear culled.
      mode = 2'd0;
      expect_tri(mkv(16'd0, 16'd0, 8'h01), mkv(16'd10, 16'd0, 8'h02), mkv(16'd0, 16'd10, 8'h03));
      push_v(mkv(16'd0, 16'd0, 8'h01)); push_v(mkv(16'd10, 16'd0, 8'h02)); push_v(mkv(16'd0, 16'd10, 8'h03));
      wait_drain("cull_ccw", 200);
      push_v(mkv(16'd0, 16'd0, 8'h04)); push_v(mkv(16'd0, 16'd10, 8'h05)); push_v(mkv(16'd10, 16'd0, 8'h06));
      wait_drain("cull_cw", 200);
      chk("cull_count_cw", TW'(cull_count), TW'(1));
      push_v(mkv(16'd0, 16'd0, 8'h07)); push_v(mkv(16'd5, 16'd5, 8'h08)); push_v(mkv(16'd10, 16'd10, 8'h09));
      wait_drain("cull_line", 200);
      chk("cull_count_line", TW'(cull_count), TW'(2));
      chk("cull_prim_count", TW'(prim_count), TW'(1));
`else
      chk("cull_count_tied", TW'(cull_count), TW'(0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
